// File: rtl/sa_pkg.sv
// sa_pkg: shared types and sizing helpers for the systolic tile sequencer.
// Holds the sequencer state encoding, the reduction-index width derivation
// and the drain length of the wavefront for a given array shape.
package sa_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    UNLOAD = 3'd4,
    DONE   = 3'd5
  } sa_state_e;

  // Width of the reduction index; kept at least 1 bit so KMAX=1 still elaborates.
  function automatic int kw_of(input int kmax);
    return (kmax > 1) ? $clog2(kmax) : 1;
  endfunction

  // Width of the unload row index.
  function automatic int rw_of(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // Cycles needed after the last feed for the wavefront to leave PE[ROWS-1][COLS-1].
  function automatic int drain_cyc(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/sa_ctrl_if.sv
// sa_ctrl_if: result stream from the tile sequencer, one array row per beat.
// master drives valid/row/data, slave returns ready.
interface sa_ctrl_if
  import sa_pkg::*;
#(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int OUTWIDTH = 32
);

  localparam int RW = rw_of(ROWS);

  logic                               res_valid;
  logic                               res_ready;
  logic [RW-1:0]                      res_row;
  logic [COLS-1:0][OUTWIDTH-1:0]      res_data;

  modport master (
    output res_valid,
    output res_row,
    output res_data,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_row,
    input  res_data,
    output res_ready
  );

endinterface

// File: rtl/sa_skew.sv
// sa_skew: fixed-depth lane delay line for the systolic input skew.
// Registers reset to zero and can be flushed synchronously with clr so a new
// or aborted tile never sees stale operands. DEPTH=0 is a plain wire.
module sa_skew #(
  parameter int W     = 8,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rstn, clr};
    assign q = d;
  end else begin : g_dly
    logic [DEPTH-1:0][W-1:0] sr;

    // Shift register: stage 0 takes the lane input, each stage adds one cycle.
    always_ff @(posedge clk) begin
      if (!rstn || clr) begin
        sr <= '0;
      end else begin
        sr[0] <= d;
        for (int s = 1; s < DEPTH; s++) begin
          sr[s] <= sr[s-1];
        end
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/sa_ctrl.sv
// sa_ctrl: output-stationary tile sequencer for the systolic PE array.
// One start clears the accumulators, streams k reduction steps through the
// per-lane skew lines, waits for the wavefront to drain, then unloads the
// ROWS x COLS results one row per beat on the res stream.
// Optional build macro: SA_CTRL_ABORT_EN adds an abort input that returns
// any running tile to IDLE on the next edge, clearing array and skew lines.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; k_len is clamped and latched on start
// CLEAR  | one cycle, array accumulators and skew lines cleared
// FEED   | k buffer reads, address = k_cnt (0..k-1)
// DRAIN  | DRAIN_CYC cycles for the last wavefront to reach the far PE
// UNLOAD | one row per accepted beat, row 0..ROWS-1
// DONE   | one-cycle done pulse
module sa_ctrl
  import sa_pkg::*;
#(
  parameter  int ROWS     = 8,
  parameter  int COLS     = 8,
  parameter  int INWIDTH  = 8,
  parameter  int OUTWIDTH = 32,
  parameter  int KMAX     = 256,
  localparam int KW       = kw_of(KMAX),
  localparam int RW       = rw_of(ROWS)
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  start,
  input  logic [KW:0]                           k_len,
`ifdef SA_CTRL_ABORT_EN
  input  logic                                  abort,
`endif
  output logic                                  busy,
  output logic                                  done,
  output logic                                  buf_rd_en,
  output logic [KW-1:0]                         buf_rd_addr,
  input  logic [ROWS-1:0][INWIDTH-1:0]          w_rd_data,
  input  logic [COLS-1:0][INWIDTH-1:0]          a_rd_data,
  output logic                                  arr_clr_n,
  output logic                                  arr_fire,
  output logic [ROWS-1:0][INWIDTH-1:0]          arr_in_w,
  output logic [COLS-1:0][INWIDTH-1:0]          arr_in_a,
  input  logic [ROWS*COLS-1:0][OUTWIDTH-1:0]    arr_outs,
  sa_ctrl_if.master                             res
);

  localparam int          DCYC   = drain_cyc(ROWS, COLS);
  localparam int          DW     = $clog2(DCYC + 1);
  localparam logic [KW:0] KMAX_K = (KW+1)'(KMAX);
  localparam logic [KW:0] K_ONE  = (KW+1)'(1);

  sa_state_e                    state;
  sa_state_e                    state_nxt;
  logic [KW:0]                  k_lat;
  logic [KW:0]                  k_clamp;
  logic [KW-1:0]                k_cnt;
  logic [DW-1:0]                drain_cnt;
  logic [RW-1:0]                row_cnt;
  logic                         k_last;
  logic                         row_last;
  logic                         beat_acc;
  logic                         abort_w;
  logic                         abort_q;
  logic                         skew_clr;
  logic [ROWS-1:0][INWIDTH-1:0] w_gated;
  logic [COLS-1:0][INWIDTH-1:0] a_gated;

`ifdef SA_CTRL_ABORT_EN
  assign abort_w = abort && (state != IDLE);
`else
  assign abort_w = 1'b0;
`endif

  assign k_clamp  = (k_len > KMAX_K) ? KMAX_K : k_len;
  assign k_last   = ({1'b0, k_cnt} == (k_lat - K_ONE));
  assign row_last = (row_cnt == RW'(ROWS - 1));
  assign beat_acc = (state == UNLOAD) && res.res_ready && !abort_w;

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived control outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    buf_rd_en = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        state_nxt = (k_lat == '0) ? UNLOAD : FEED;
      end
      FEED: begin
        buf_rd_en = 1'b1;
        if (k_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == '0) state_nxt = UNLOAD;
      end
      UNLOAD: begin
        if (beat_acc && row_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort_w) begin
      state_nxt = IDLE;
      done      = 1'b0;
    end
  end

  // Tile length is captured once so a changing k_len cannot disturb a running tile.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      k_lat <= '0;
    end else if (state == IDLE && start) begin
      k_lat <= k_clamp;
    end
  end

  // Reduction index: counts up through FEED, parked at zero elsewhere.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      k_cnt <= '0;
    end else if (state == FEED && !abort_w) begin
      k_cnt <= k_cnt + 1'b1;
    end else begin
      k_cnt <= '0;
    end
  end

  // Drain timer: reloaded outside DRAIN, counts down to its terminal zero inside it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      drain_cnt <= DW'(DCYC - 1);
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt - 1'b1;
    end else begin
      drain_cnt <= DW'(DCYC - 1);
    end
  end

  // Unload row index: advances only on an accepted beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      row_cnt <= '0;
    end else if (state != UNLOAD || abort_w) begin
      row_cnt <= '0;
    end else if (beat_acc) begin
      row_cnt <= row_last ? '0 : row_cnt + 1'b1;
    end
  end

  // arr_fire marks the cycle buffer data is valid (one cycle after the read);
  // abort_q stretches the array clear into the cycle after an abort.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      arr_fire <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      arr_fire <= (state == FEED) && !abort_w;
      abort_q  <= abort_w;
    end
  end

  assign arr_clr_n   = !((state == CLEAR) || abort_q);
  assign skew_clr    = (state == CLEAR) || abort_q || abort_w;
  assign buf_rd_addr = buf_rd_en ? k_cnt : '0;

  // Buffer data outside the fire window is don't-care; force lanes to zero there.
  assign w_gated = arr_fire ? w_rd_data : '0;
  assign a_gated = arr_fire ? a_rd_data : '0;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_w_lane
    sa_skew #(.W(INWIDTH), .DEPTH(gi)) u_skew (
      .clk  (clk),
      .rstn (rstn),
      .clr  (skew_clr),
      .d    (w_gated[gi]),
      .q    (arr_in_w[gi])
    );
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_a_lane
    sa_skew #(.W(INWIDTH), .DEPTH(gj)) u_skew (
      .clk  (clk),
      .rstn (rstn),
      .clr  (skew_clr),
      .d    (a_gated[gj]),
      .q    (arr_in_a[gj])
    );
  end

  assign res.res_valid = (state == UNLOAD);
  assign res.res_row   = row_cnt;
  assign res.res_data  = arr_outs[32'(row_cnt) * COLS +: COLS];

endmodule

// File: tb/tb_sa_ctrl.sv
// tb_sa_ctrl: self-checking bench for sa_ctrl. Buffers and a behavioural PE
// array surround the DUT; expectations come from the tile timing rules and
// from direct dot products of the buffer contents.
module tb_sa_ctrl;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int IW   = 8;
  localparam int OW   = 32;
  localparam int KMAX = 256;
  localparam int KW   = 8;

  logic clk, rstn, start, abort;
  logic [KW:0] k_len;
  logic busy, done, buf_rd_en, arr_clr_n, arr_fire;
  logic [KW-1:0] buf_rd_addr;
  logic [ROWS-1:0][IW-1:0] w_rd_data, arr_in_w;
  logic [COLS-1:0][IW-1:0] a_rd_data, arr_in_a;
  logic [ROWS*COLS-1:0][OW-1:0] arr_outs;

  sa_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .OUTWIDTH(OW)) res_if ();

  sa_ctrl #(.ROWS(ROWS), .COLS(COLS), .INWIDTH(IW), .OUTWIDTH(OW), .KMAX(KMAX)) dut (
    .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
`ifdef SA_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .w_rd_data(w_rd_data), .a_rd_data(a_rd_data), .arr_clr_n(arr_clr_n),
    .arr_fire(arr_fire), .arr_in_w(arr_in_w), .arr_in_a(arr_in_a),
    .arr_outs(arr_outs), .res(res_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [IW-1:0] wmem [KMAX][ROWS];
  logic [IW-1:0] amem [KMAX][COLS];
  logic [OW-1:0] exp_res [ROWS][COLS];
  int n_cmp = 0;
  int n_bad = 0;
  int rel;

  // Tile buffers: one-cycle read latency, random junk when not read.
  always @(posedge clk) begin
    if (buf_rd_en) begin
      for (int r = 0; r < ROWS; r++) w_rd_data[r] <= wmem[buf_rd_addr][r];
      for (int c = 0; c < COLS; c++) a_rd_data[c] <= amem[buf_rd_addr][c];
    end else begin
      w_rd_data <= {$urandom, $urandom};
      a_rd_data <= {$urandom, $urandom};
    end
  end

  // Behavioural array: PE[r][c] sees west lane r delayed c cycles and north lane c delayed r.
  logic [IW-1:0] whist [ROWS][COLS];
  logic [IW-1:0] ahist [COLS][ROWS];
  logic [OW-1:0] acc   [ROWS][COLS];
  logic [IW-1:0] pw, pa;
  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        pw = (c == 0) ? arr_in_w[r] : whist[r][c];
        pa = (r == 0) ? arr_in_a[c] : ahist[c][r];
        if (!rstn || !arr_clr_n) acc[r][c] <= '0;
        else acc[r][c] <= acc[r][c] + OW'(pw) * OW'(pa);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int d = 1; d < COLS; d++) begin
        if (!rstn || !arr_clr_n) whist[r][d] <= '0;
        else whist[r][d] <= (d == 1) ? arr_in_w[r] : whist[r][d-1];
      end
    end
    for (int c = 0; c < COLS; c++) begin
      for (int d = 1; d < ROWS; d++) begin
        if (!rstn || !arr_clr_n) ahist[c][d] <= '0;
        else ahist[c][d] <= (d == 1) ? arr_in_a[c] : ahist[c][d-1];
      end
    end
  end

  always_comb begin
    arr_outs = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        arr_outs[r*COLS + c] = acc[r][c];
  end

  task automatic chk_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s rel_cyc=%0d got=%0h want=%0h", tag, rel, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk_eq({tag, "_busy"}, busy, 1'b0);
    chk_eq({tag, "_done"}, done, 1'b0);
    chk_eq({tag, "_rd_en"}, buf_rd_en, 1'b0);
    chk_eq({tag, "_rd_addr"}, buf_rd_addr, 0);
    chk_eq({tag, "_fire"}, arr_fire, 1'b0);
    chk_eq({tag, "_valid"}, res_if.res_valid, 1'b0);
    chk_eq({tag, "_row"}, res_if.res_row, 0);
    chk_eq({tag, "_clr_n"}, arr_clr_n, 1'b1);
    chk_eq({tag, "_in_w"}, arr_in_w, 0);
    chk_eq({tag, "_in_a"}, arr_in_a, 0);
  endtask

  // One tile. wv/av < 0 means random operands. rmode: 0 ready=1, 1 ready 1-0-0-1, 2 random.
  task automatic run_tile(input int k, input int wv, input int av, input int rmode,
                          input int restart_rel, input int rst_rel, input int abort_beat);
    int k_eff, u0, ub, done_rel, abort_rel, t;
    logic rdy, ev;
    logic [ROWS-1:0][IW-1:0] ew;
    logic [COLS-1:0][IW-1:0] ea;
    logic [COLS-1:0][OW-1:0] ed;
    k_eff = (k > KMAX) ? KMAX : k;
    for (int s = 0; s < k_eff; s++) begin
      for (int r = 0; r < ROWS; r++) wmem[s][r] = (wv < 0) ? IW'($urandom) : IW'(wv);
      for (int c = 0; c < COLS; c++) amem[s][c] = (av < 0) ? IW'($urandom) : IW'(av);
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        exp_res[r][c] = '0;
        for (int s = 0; s < k_eff; s++) exp_res[r][c] += OW'(wmem[s][r]) * OW'(amem[s][c]);
      end
    u0 = (k_eff == 0) ? 2 : k_eff + 2 + ROWS + COLS;
    ub = 0; done_rel = 1 << 30; abort_rel = -1;
    repeat (2) @(negedge clk);
    rel = 0;
    start = 1'b1; k_len = (KW+1)'(k); res_if.res_ready = 1'b0;
    chk_eq("idle_busy", busy, 1'b0);
    while (1) begin
      @(negedge clk);
      rel++;
      start = (rel == restart_rel);
      if (rel > 2000) begin
        chk_eq("tile_timeout", rel, done_rel);
        return;
      end
      if (rst_rel >= 0 && rel == rst_rel + 1) begin
        rstn = 1'b1;
        chk_reset("midrst");
        return;
      end
`ifdef SA_CTRL_ABORT_EN
      if (abort_rel >= 0 && rel == abort_rel + 1) begin
        abort = 1'b0;
        chk_eq("abort_busy", busy, 1'b0);
        chk_eq("abort_done", done, 1'b0);
        chk_eq("abort_valid", res_if.res_valid, 1'b0);
        chk_eq("abort_clr_n", arr_clr_n, 1'b0);
        chk_eq("abort_fire", arr_fire, 1'b0);
        chk_eq("abort_in_w", arr_in_w, 0);
        chk_eq("abort_in_a", arr_in_a, 0);
        @(negedge clk); rel++;
        chk_eq("abort_clr_rel", arr_clr_n, 1'b1);
        chk_eq("abort_nodone", done, 1'b0);
        return;
      end
`endif
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = (((rel - u0) % 4) == 0) || (((rel - u0) % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      res_if.res_ready = rdy;
      chk_eq("busy", busy, (rel >= 1) && (rel <= done_rel));
      chk_eq("done", done, rel == done_rel);
      chk_eq("clr_n", arr_clr_n, rel != 1);
      chk_eq("rd_en", buf_rd_en, (rel >= 2) && (rel <= k_eff + 1));
      if (rel >= 2 && rel <= k_eff + 1) chk_eq("rd_addr", buf_rd_addr, rel - 2);
      chk_eq("fire", arr_fire, (rel >= 3) && (rel <= k_eff + 2));
      for (int i = 0; i < ROWS; i++) begin
        t = rel - 3 - i;
        ew[i] = (t >= 0 && t < k_eff) ? wmem[t][i] : '0;
      end
      for (int j = 0; j < COLS; j++) begin
        t = rel - 3 - j;
        ea[j] = (t >= 0 && t < k_eff) ? amem[t][j] : '0;
      end
      chk_eq("in_w", arr_in_w, ew);
      chk_eq("in_a", arr_in_a, ea);
      ev = (rel >= u0) && (ub < ROWS);
      chk_eq("res_valid", res_if.res_valid, ev);
      if (ev) begin
        for (int c = 0; c < COLS; c++) ed[c] = exp_res[ub][c];
        chk_eq("res_row", res_if.res_row, ub);
        chk_eq("res_data", res_if.res_data, ed);
      end
      if (rel == done_rel + 1) return;
      if (rel == rst_rel) rstn = 1'b0;
      if (ev) begin
        if (abort_beat == ub) begin
          abort = 1'b1;
          abort_rel = rel;
        end else if (rdy) begin
          ub++;
          if (ub == ROWS) done_rel = rel + 1;
        end
      end
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; k_len = '0;
    res_if.res_ready = 1'b0;
    rel = 0;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rstn = 1'b1;
    run_tile(1, 1, 2, 0, -1, -1, -1);
    run_tile(4, 1, 3, 0, -1, -1, -1);
    run_tile(4, -1, -1, 1, -1, -1, -1);
    run_tile(0, -1, -1, 0, -1, -1, -1);
    run_tile(5, -1, -1, 2, 10, -1, -1);
    run_tile(8, -1, -1, 0, -1, 5, -1);
    run_tile(6, -1, -1, 2, -1, -1, -1);
    for (int n = 0; n < 4; n++)
      run_tile(int'($urandom_range(1, 24)), -1, -1, int'($urandom_range(0, 2)), -1, -1, -1);
    run_tile(300, -1, -1, 0, -1, -1, -1);
`ifdef SA_CTRL_ABORT_EN
    run_tile(4, -1, -1, 0, -1, -1, 3);
    run_tile(3, -1, -1, 0, -1, -1, -1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
